// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned subtractor: computes a_in - b_in - bin_init one bit per
// clock, LSB first, using a single full-subtractor cell and a borrow flop.
// Trades latency (WIDTH cycles per operation) for minimal logic.
//
// Parameters:
//   WIDTH     operand/result width in bits (2..32), default 8
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     operation request, sampled only in IDLE or DONE
//   a_in      minuend, captured on an accepted start
//   b_in      subtrahend, captured on an accepted start
//   bin_init  initial borrow-in, captured on an accepted start
//   busy      high while the bit-serial datapath is shifting
//   done      one-cycle pulse when differ/borrow have just been updated
//   differ    registered difference (mod 2^WIDTH)
//   borrow    registered final borrow-out (1 when a_in < b_in + bin_init)
//   ovf       (only with SERIAL_SUB_OVF_EN) registered two's-complement
//             overflow flag, updated together with differ
//
// Optional feature macro: SERIAL_SUB_OVF_EN
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             bin_init,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] differ,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] r_sh_reg;
    logic             br_reg;
    logic [CW-1:0]    cnt_reg;

    // Full-subtractor cell on the current LSBs of the operand shifters.
    logic bit_a;
    logic bit_b;
    logic d_bit;
    logic br_next;

    always_comb begin
        bit_a   = a_sh_reg[0];
        bit_b   = b_sh_reg[0];
        d_bit   = bit_a ^ bit_b ^ br_reg;
        br_next = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_reg);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            r_sh_reg  <= '0;
            br_reg    <= 1'b0;
            cnt_reg   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            differ    <= '0;
            borrow    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    // done is a single-cycle pulse in both accepting states.
                    done <= 1'b0;
                    if (start) begin
                        a_sh_reg  <= a_in;
                        b_sh_reg  <= b_in;
                        br_reg    <= bin_init;
                        r_sh_reg  <= '0;
                        cnt_reg   <= '0;
                        busy      <= 1'b1;
                        state_reg <= S_SHIFT;
                    end else begin
                        busy      <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end

                S_SHIFT: begin
                    a_sh_reg <= {1'b0, a_sh_reg[WIDTH-1:1]};
                    b_sh_reg <= {1'b0, b_sh_reg[WIDTH-1:1]};
                    r_sh_reg <= {d_bit, r_sh_reg[WIDTH-1:1]};
                    br_reg   <= br_next;
                    cnt_reg  <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_CNT) begin
                        // Final bit: publish the full result straight from the
                        // cell so differ never exposes a partial value.
                        differ    <= {d_bit, r_sh_reg[WIDTH-1:1]};
                        borrow    <= br_next;
`ifdef SERIAL_SUB_OVF_EN
                        // On the last shift the LSBs hold the operand MSBs.
                        ovf       <= (bit_a != bit_b) && (d_bit != bit_a);
`endif
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= S_DONE;
                    end
                end

                default: begin
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule
